// File: rtl/fifo_ctrl_pack.sv
// Narrow-in / wide-out FWFT FIFO: one DATA_WIDTH word per write, one 2*DATA_WIDTH pair per read.
// Define FIFO_PACK_ERR_EN to add sticky err_ovf / err_udf outputs.
module fifo_ctrl_pack #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    rd,
  output logic [2*DATA_WIDTH-1:0] r_data,
  output logic                    full,
  output logic                    empty,
  output logic [ADDR_WIDTH:0]     level
`ifdef FIFO_PACK_ERR_EN
  ,
  output logic                    err_ovf,
  output logic                    err_udf
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_hi;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_ok;
  logic                  rd_ok;

  // Each side is qualified against the registered flags, so a read never frees room for a same-cycle write.
  always_comb begin
    wr_ok      = wr && !full;
    rd_ok      = rd && !empty;
    count_next = count + (ADDR_WIDTH+1)'(wr_ok) - ((ADDR_WIDTH+1)'(rd_ok) << 1);
    rd_ptr_hi  = rd_ptr + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_WIDTH'(2);
      count <= count_next;
      full  <= (count_next == (ADDR_WIDTH+1)'(DEPTH));
      empty <= (count_next < (ADDR_WIDTH+1)'(2));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= w_data;
  end

  assign level  = count;
  assign r_data = {mem[rd_ptr_hi], mem[rd_ptr]};

`ifdef FIFO_PACK_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (wr && full)  err_ovf <= 1'b1;
      if (rd && empty) err_udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl_pack.sv
// Self-checking bench for fifo_ctrl_pack against a byte-queue reference model.
module tb_fifo_ctrl_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  w_data = '0;
  logic [15:0] r_data;
  logic        full;
  logic        empty;
  logic [3:0]  level;
`ifdef FIFO_PACK_ERR_EN
  logic        err_ovf;
  logic        err_udf;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0] mq[$];
  bit m_ovf = 0;
  bit m_udf = 0;

  fifo_ctrl_pack #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .w_data(w_data),
    .rd(rd),
    .r_data(r_data),
    .full(full),
    .empty(empty),
    .level(level)
`ifdef FIFO_PACK_ERR_EN
    ,
    .err_ovf(err_ovf),
    .err_udf(err_udf)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_cycle(input bit w, input logic [7:0] d, input bit r);
    bit wok;
    bit rok;
    wr = w; w_data = d; rd = r;
    wok = w && (mq.size() < 8);
    rok = r && (mq.size() >= 2);
    if (w && !wok) m_ovf = 1;
    if (r && !rok) m_udf = 1;
    @(posedge clk); #1;
    if (rok) begin
      void'(mq.pop_front());
      void'(mq.pop_front());
    end
    if (wok) mq.push_back(d);
    wr = 0; rd = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    apply_reset();
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
`ifdef FIFO_PACK_ERR_EN
    total++; if ({err_ovf, err_udf} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", {err_ovf, err_udf}); end
`endif
  endtask

  task automatic test_pair();
    do_cycle(1, 8'h11, 0);
    do_cycle(1, 8'h22, 0);
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL pair_empty: got %b want 0", empty); end
    total++; if (level !== 4'd2) begin bad++; $display("FAIL pair_level: got %0d want 2", level); end
    total++; if (r_data !== 16'h2211) begin bad++; $display("FAIL pair_rdata: got %h want 2211", r_data); end
    do_cycle(0, 8'h00, 1);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL pair_pop_empty: got %b want 1", empty); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL pair_pop_level: got %0d want 0", level); end
  endtask

  task automatic test_odd();
    apply_reset();
    do_cycle(1, 8'hA1, 0);
    total++; if (level !== 4'd1) begin bad++; $display("FAIL odd_level: got %0d want 1", level); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL odd_empty: got %b want 1", empty); end
    do_cycle(0, 8'h00, 1);
    total++; if (level !== 4'd1) begin bad++; $display("FAIL odd_rd_ignored: got %0d want 1", level); end
`ifdef FIFO_PACK_ERR_EN
    total++; if (err_udf !== 1'b1) begin bad++; $display("FAIL odd_err_udf: got %b want 1", err_udf); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL odd_err_ovf: got %b want 0", err_ovf); end
`endif
    do_cycle(1, 8'hB2, 0);
    total++; if (r_data !== 16'hB2A1) begin bad++; $display("FAIL odd_complete: got %h want b2a1", r_data); end
  endtask

  task automatic test_fill();
    logic [15:0] exp;
    apply_reset();
    for (int i = 0; i < 8; i++) do_cycle(1, 8'(i), 0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full); end
    total++; if (level !== 4'd8) begin bad++; $display("FAIL fill_level: got %0d want 8", level); end
    do_cycle(1, 8'hFF, 0);
    total++; if (level !== 4'd8) begin bad++; $display("FAIL fill_ovf_level: got %0d want 8", level); end
`ifdef FIFO_PACK_ERR_EN
    total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL fill_err_ovf: got %b want 1", err_ovf); end
`endif
    for (int i = 0; i < 4; i++) begin
      exp = {8'(2*i+1), 8'(2*i)};
      total++; if (r_data !== exp) begin bad++; $display("FAIL fill_read%0d: got %h want %h", i, r_data, exp); end
      do_cycle(0, 8'h00, 1);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_drained: got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    logic [7:0] v = 8'h40;
    apply_reset();
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 6; i++) begin
        do_cycle(1, v, 0);
        v++;
      end
      for (int i = 0; i < 2; i++) begin
        exp = {mq[1], mq[0]};
        total++; if (r_data !== exp) begin bad++; $display("FAIL wrap_r%0d_p%0d: got %h want %h", round, i, r_data, exp); end
        do_cycle(0, 8'h00, 1);
      end
      total++; if (level !== 4'(mq.size())) begin bad++; $display("FAIL wrap_level%0d: got %0d want %0d", round, level, mq.size()); end
    end
  endtask

  task automatic test_simul();
    logic [7:0] w3;
    apply_reset();
    do_cycle(1, 8'hC1, 0);
    do_cycle(1, 8'hC2, 0);
    do_cycle(1, 8'hC3, 0);
    w3 = 8'hC3;
    do_cycle(1, 8'h5A, 1);
    total++; if (level !== 4'd2) begin bad++; $display("FAIL simul_level: got %0d want 2", level); end
    total++; if (r_data !== {8'h5A, w3}) begin bad++; $display("FAIL simul_rdata: got %h want %h", r_data, {8'h5A, w3}); end
    for (int i = 0; i < 6; i++) do_cycle(1, 8'(8'hD0 + i), 0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL simul_full: got %b want 1", full); end
    do_cycle(1, 8'hEE, 1);
    total++; if (level !== 4'd6) begin bad++; $display("FAIL simul_full_level: got %0d want 6", level); end
    total++; if (r_data !== 16'hD1D0) begin bad++; $display("FAIL simul_full_rdata: got %h want d1d0", r_data); end
  endtask

  task automatic test_midreset();
    apply_reset();
    for (int i = 0; i < 5; i++) do_cycle(1, 8'(8'h90 + i), 0);
    total++; if (level !== 4'd5) begin bad++; $display("FAIL midrst_pre_level: got %0d want 5", level); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (level !== 4'd0) begin bad++; $display("FAIL midrst_level: got %0d want 0", level); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL midrst_full: got %b want 0", full); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL midrst_empty: got %b want 1", empty); end
    @(posedge clk); #1;
    apply_reset();
    do_cycle(1, 8'h33, 0);
    do_cycle(1, 8'h44, 0);
    total++; if (r_data !== 16'h4433) begin bad++; $display("FAIL midrst_rdata: got %h want 4433", r_data); end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      do_cycle(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 35));
      total++; if (level !== 4'(mq.size())) begin bad++; $display("FAIL rand_level@%0d: got %0d want %0d", n, level, mq.size()); end
      total++; if (full !== (mq.size() == 8)) begin bad++; $display("FAIL rand_full@%0d: got %b want %b", n, full, mq.size() == 8); end
      total++; if (empty !== (mq.size() < 2)) begin bad++; $display("FAIL rand_empty@%0d: got %b want %b", n, empty, mq.size() < 2); end
      if (mq.size() >= 2) begin
        exp = {mq[1], mq[0]};
        total++; if (r_data !== exp) begin bad++; $display("FAIL rand_rdata@%0d: got %h want %h", n, r_data, exp); end
      end
`ifdef FIFO_PACK_ERR_EN
      total++; if ({err_ovf, err_udf} !== {m_ovf, m_udf}) begin bad++; $display("FAIL rand_err@%0d: got %b want %b", n, {err_ovf, err_udf}, {m_ovf, m_udf}); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_odd();
    test_fill();
    test_wrap();
    test_simul();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
